// File: rtl/pac_rr_req_queue.sv
// pac_rr_req_queue: four independent circular request queues feeding the
// PAC-RR arbiter core. req_o/full_o/level_o are decoded from registered
// occupancy only, so grant/pop never reach the request path combinationally.
// Optional sticky status flags (ovf_o, udf_o, err_clr_i) are built only when
// PAC_RRQ_STATUS_EN is defined; otherwise the flags are tied to 0.

module pac_rr_req_queue_lane #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,        // pre-qualified: only asserted when level != 0
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic [DW-1:0] head_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][DW-1:0] r_mem;
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [LW-1:0]            r_level;
    logic                     w_full;
    logic                     w_push_acc;

    assign w_full = (r_level == LW'(DEPTH));
    // A same-cycle pop frees the head slot, so a push while full is still taken.
    assign w_push_acc = push_i & (~w_full | pop_i);

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (w_push_acc) r_mem[r_wr_ptr] <= push_data_i;
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks net push/pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (pop_i)      r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push_acc, pop_i})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign level_o = r_level;
    assign full_o  = w_full;
    assign head_o  = r_mem[r_rd_ptr];
endmodule

module pac_rr_req_queue #(
    parameter  int DEPTH = 4,
    parameter  int DW    = 8,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [3:0]      push_i,
    input  logic [4*DW-1:0] push_data_i,
    output logic [3:0]      full_o,
    output logic [3:0]      req_o,
    input  logic [3:0]      grant_i,
    input  logic            pop_i,
    output logic            head_valid_o,
    output logic [DW-1:0]   head_data_o,
    output logic [4*LW-1:0] level_o,
    output logic [3:0]      ovf_o,
    output logic            udf_o,
    input  logic            err_clr_i
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0][LW-1:0] w_level;
    logic [NUM_LANES-1:0][DW-1:0] w_head;
    logic [NUM_LANES-1:0]         w_full;
    logic [NUM_LANES-1:0]         w_req;
    logic [NUM_LANES-1:0]         w_lane_pop;
    logic                         w_grant_onehot;
    logic                         w_head_valid;
    logic                         w_pop_ok;

    // A pop is only honoured for a one-hot grant onto a non-empty queue.
    assign w_grant_onehot = (grant_i != 4'd0) && ((grant_i & (grant_i - 4'd1)) == 4'd0);
    assign w_head_valid   = w_grant_onehot & (|(grant_i & w_req));
    assign w_pop_ok       = pop_i & w_head_valid;
    assign w_lane_pop     = w_pop_ok ? grant_i : 4'd0;

    generate
        for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
            pac_rr_req_queue_lane #(
                .DEPTH (DEPTH),
                .DW    (DW),
                .LW    (LW)
            ) u_lane (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .push_i      (push_i[k]),
                .push_data_i (push_data_i[k*DW +: DW]),
                .pop_i       (w_lane_pop[k]),
                .level_o     (w_level[k]),
                .full_o      (w_full[k]),
                .head_o      (w_head[k])
            );
            assign w_req[k] = (w_level[k] != '0);
        end
    endgenerate

    assign req_o        = w_req;
    assign full_o       = w_full;
    assign level_o      = w_level;
    assign head_valid_o = w_head_valid;

    // Head mux: grant is one-hot whenever head is valid, otherwise drive zero.
    always_comb begin
        head_data_o = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (w_head_valid && grant_i[k]) head_data_o = w_head[k];
        end
    end

`ifdef PAC_RRQ_STATUS_EN
    logic [NUM_LANES-1:0] w_ovf_evt;
    logic                 w_udf_evt;
    logic [NUM_LANES-1:0] r_ovf;
    logic                 r_udf;

    // Overflow only when a full queue is pushed without a same-cycle pop.
    assign w_ovf_evt = push_i & w_full & ~w_lane_pop;
    assign w_udf_evt = pop_i & ~w_pop_ok;

    // Sticky flags: a new event in the clear cycle keeps the flag set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovf <= '0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_evt | (r_ovf & {NUM_LANES{~err_clr_i}});
            r_udf <= w_udf_evt | (r_udf & ~err_clr_i);
        end
    end

    assign ovf_o = r_ovf;
    assign udf_o = r_udf;
`else
    logic w_unused_err_clr;

    // Status flags are not built; the clear input is accepted and ignored.
    assign w_unused_err_clr = err_clr_i;
    assign ovf_o = '0;
    assign udf_o = 1'b0;
`endif
endmodule

// File: tb/tb_pac_rr_req_queue.sv
// Directed bench for pac_rr_req_queue (DEPTH=4, DW=8). Payload order is
// checked by a scoreboard monitor; occupancy/flags are checked inline.
module tb_pac_rr_req_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int LW    = 3;
`ifdef PAC_RRQ_STATUS_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      push_i;
    logic [4*DW-1:0] push_data_i;
    logic [3:0]      full_o;
    logic [3:0]      req_o;
    logic [3:0]      grant_i;
    logic            pop_i;
    logic            head_valid_o;
    logic [DW-1:0]   head_data_o;
    logic [4*LW-1:0] level_o;
    logic [3:0]      ovf_o;
    logic            udf_o;
    logic            err_clr_i;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q [4][$];

    always #5 clk = ~clk;

    pac_rr_req_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .push_i       (push_i),
        .push_data_i  (push_data_i),
        .full_o       (full_o),
        .req_o        (req_o),
        .grant_i      (grant_i),
        .pop_i        (pop_i),
        .head_valid_o (head_valid_o),
        .head_data_o  (head_data_o),
        .level_o      (level_o),
        .ovf_o        (ovf_o),
        .udf_o        (udf_o),
        .err_clr_i    (err_clr_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] lvl(input int k);
        return level_o[k*LW +: LW];
    endfunction

    // One clock of stimulus; inputs return to idle just after the edge.
    task automatic cyc(input logic [3:0] p, input logic [31:0] d, input logic [3:0] g,
                       input logic pp, input logic clr);
        push_i = p; push_data_i = d; grant_i = g; pop_i = pp; err_clr_i = clr;
        @(posedge clk); #1;
        push_i = '0; push_data_i = '0; grant_i = '0; pop_i = 1'b0; err_clr_i = 1'b0;
    endtask

    task automatic push1(input int k, input logic [7:0] d);
        logic [31:0] dd;
        dd = 32'(d) << (8 * k);
        exp_q[k].push_back(d);
        cyc(4'b0001 << k, dd, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic pop1(input int k);
        cyc(4'd0, 32'd0, 4'b0001 << k, 1'b1, 1'b0);
    endtask

    // Scoreboard monitor: every accepted beat must match the oldest expected payload.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && pop_i && head_valid_o) begin
                int k;
                k = 0;
                for (int i = 0; i < 4; i++) if (grant_i[i]) k = i;
                if (exp_q[k].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: lane %0d presented 0x%0h, expected no entry", k, head_data_o);
                end else begin
                    check($sformatf("head_data_lane%0d", k), 32'(head_data_o), 32'(exp_q[k].pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; push_i = '0; push_data_i = '0; grant_i = 4'b0100; pop_i = 1'b0; err_clr_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_req", req_o, 0);
        check("rst_full", full_o, 0);
        check("rst_level", level_o, 0);
        check("rst_head_valid", head_valid_o, 0);
        check("rst_head_data", head_data_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_udf", udf_o, 0);
        grant_i = '0; rst = 1'b0;
        @(posedge clk); #1;

        // Basic push/pop on requester 2
        push1(2, 8'hA1);
        push1(2, 8'hA2);
        check("t1_req", req_o, 4'b0100);
        check("t1_lvl2", lvl(2), 2);
        pop1(2);
        check("t1_lvl2_after1", lvl(2), 1);
        pop1(2);
        check("t1_req_empty", req_o, 0);
        check("t1_lvl2_empty", lvl(2), 0);
        grant_i = 4'b0100; #1;
        check("t1_head_valid_empty", head_valid_o, 0);
        grant_i = '0;

        // Overflow on requester 0: fifth push dropped
        for (int i = 0; i < 4; i++) push1(0, 8'h10 + 8'(i));
        check("t2_full", full_o, 4'b0001);
        check("t2_lvl0", lvl(0), 4);
        check("t2_ovf_pre", ovf_o, 0);
        cyc(4'b0001, 32'h14, 4'd0, 1'b0, 1'b0);
        check("t2_lvl0_drop", lvl(0), 4);
        check("t2_ovf", ovf_o, {3'b000, STAT});
        cyc(4'd0, 32'd0, 4'd0, 1'b0, 1'b1);
        check("t2_ovf_clr", ovf_o, 0);
        for (int i = 0; i < 4; i++) pop1(0);
        check("t2_lvl0_drained", lvl(0), 0);
        check("t2_full_drained", full_o, 0);

        // Push and pop on a full queue in the same cycle
        for (int i = 0; i < 4; i++) push1(1, 8'h20 + 8'(i));
        exp_q[1].push_back(8'h55);
        cyc(4'b0010, 32'h5500, 4'b0010, 1'b1, 1'b0);
        check("t3_lvl1", lvl(1), 4);
        check("t3_full", full_o, 4'b0010);
        check("t3_ovf", ovf_o, 0);
        for (int i = 0; i < 4; i++) pop1(1);
        check("t3_lvl1_drained", lvl(1), 0);
        check("t3_udf", udf_o, 0);

        // Bad pops
        cyc(4'd0, 32'd0, 4'd0, 1'b1, 1'b0);
        check("t4_udf_nogrant", udf_o, STAT);
        check("t4_req", req_o, 0);
        cyc(4'd0, 32'd0, 4'd0, 1'b0, 1'b1);
        check("t4_udf_clr", udf_o, 0);
        exp_q[0].push_back(8'h30);
        exp_q[1].push_back(8'h31);
        cyc(4'b0011, 32'h3130, 4'd0, 1'b0, 1'b0);
        check("t4_req_two", req_o, 4'b0011);
        grant_i = 4'b0011; #1;
        check("t4_head_valid_multi", head_valid_o, 0);
        check("t4_head_data_multi", head_data_o, 0);
        cyc(4'd0, 32'd0, 4'b0011, 1'b1, 1'b0);
        check("t4_lvl0_multi", lvl(0), 1);
        check("t4_lvl1_multi", lvl(1), 1);
        check("t4_udf_multi", udf_o, STAT);
        cyc(4'd0, 32'd0, 4'd0, 1'b1, 1'b1);
        check("t4_udf_clr_collide", udf_o, STAT);
        cyc(4'd0, 32'd0, 4'd0, 1'b0, 1'b1);
        check("t4_udf_clr2", udf_o, 0);
        grant_i = 4'b0100; #1;
        check("t4_head_valid_emptyq", head_valid_o, 0);
        cyc(4'd0, 32'd0, 4'b0100, 1'b1, 1'b0);
        check("t4_udf_emptyq", udf_o, STAT);
        check("t4_lvl2_emptyq", lvl(2), 0);
        cyc(4'd0, 32'd0, 4'd0, 1'b0, 1'b1);
        // Push+pop into an empty queue: push lands, pop is an error
        exp_q[2].push_back(8'h40);
        cyc(4'b0100, 32'h00400000, 4'b0100, 1'b1, 1'b0);
        check("t4_lvl2_pushpop_empty", lvl(2), 1);
        check("t4_udf_pushpop_empty", udf_o, STAT);
        cyc(4'd0, 32'd0, 4'd0, 1'b0, 1'b1);
        // Push+pop at level 1
        exp_q[0].push_back(8'h32);
        cyc(4'b0001, 32'h32, 4'b0001, 1'b1, 1'b0);
        check("t4_lvl0_level1", lvl(0), 1);
        check("t4_udf_level1", udf_o, 0);
        pop1(0);
        pop1(1);
        pop1(2);
        check("t4_req_drained", req_o, 0);

        // Pointer wrap on requester 3: 13 entries through a 4-deep queue
        for (int i = 0; i < 3; i++) push1(3, 8'h60 + 8'(i));
        for (int i = 3; i < 13; i++) begin
            exp_q[3].push_back(8'h60 + 8'(i));
            cyc(4'b1000, 32'(8'h60 + 8'(i)) << 24, 4'b1000, 1'b1, 1'b0);
            check($sformatf("t5_lvl3_%0d", i), lvl(3), 3);
        end
        for (int i = 0; i < 3; i++) pop1(3);
        check("t5_lvl3_drained", lvl(3), 0);

        // Asynchronous reset mid-burst
        for (int k = 0; k < 4; k++) exp_q[k].push_back(8'h80 + 8'(k));
        cyc(4'b1111, 32'h83828180, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) exp_q[k].push_back(8'h90 + 8'(k));
        cyc(4'b1111, 32'h93929190, 4'd0, 1'b0, 1'b0);
        check("t6_levels", level_o, 12'h492);
        push_i = 4'b1111; push_data_i = 32'hA3A2A1A0; grant_i = 4'b0001; pop_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("t6_req_async", req_o, 0);
        check("t6_level_async", level_o, 0);
        check("t6_head_valid_async", head_valid_o, 0);
        check("t6_head_data_async", head_data_o, 0);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        push_i = '0; push_data_i = '0; grant_i = '0; pop_i = 1'b0;
        @(posedge clk); #1;
        check("t6_level_held", level_o, 0);
        rst = 1'b0;
        push1(1, 8'h77);
        check("t6_req_after", req_o, 4'b0010);
        check("t6_lvl1_after", lvl(1), 1);
        grant_i = 4'b0010; #1;
        check("t6_head_valid_after", head_valid_o, 1);
        check("t6_head_data_after", head_data_o, 8'h77);
        pop1(1);
        check("t6_req_final", req_o, 0);

        for (int k = 0; k < 4; k++) check($sformatf("sb_left_lane%0d", k), exp_q[k].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
